// File: rtl/psg_envelope_gen_if.sv
// Sample bus between the note generator, the envelope scaler and the mixer:
// slot counter and raw sample in, scaled tagged sample out.
`timescale 1ns/1ps
interface psg_envelope_gen_if;
    logic [7:0]  cnt;
    logic [11:0] i;
    logic [19:0] o;
    logic [1:0]  o_voice;
    logic        o_vld;

    modport master (output cnt, i, input o, o_voice, o_vld);
    modport slave  (input cnt, i, output o, o_voice, o_vld);
endinterface

// File: rtl/psg_envelope_gen.sv
// Per-voice ADSR envelope generator for the 4-voice PSG; scales the
// time-multiplexed note sample by the voice's current 8-bit level.
`timescale 1ns/1ps
module psg_envelope_gen #(
    parameter int PRE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        gate,
    input  logic [3:0]        test,
    input  logic [15:0]       attack,
    input  logic [15:0]       decay,
    input  logic [15:0]       sustain,
    input  logic [15:0]       rel,
    psg_envelope_gen_if.slave bus,
    output logic [7:0]        env0,
    output logic [7:0]        env1,
    output logic [7:0]        env2,
    output logic [7:0]        env3
);
    typedef enum logic [2:0] {ST_IDLE, ST_ATTACK, ST_DECAY, ST_SUSTAIN, ST_RELEASE} st_t;

    st_t              st  [4];
    logic [7:0]       lvl [4];
    logic [PRE_W-1:0] pre [4];
    logic [3:0]       pg;

    function automatic logic [7:0] lvl_inc(input logic [7:0] l);
        return (l == 8'hFF) ? l : l + 8'd1;
    endfunction

    function automatic logic [7:0] lvl_dec(input logic [7:0] l);
        return (l == 8'h00) ? l : l - 8'd1;
    endfunction

    logic             upd;
    logic [1:0]       v;
    st_t              cur_st;
    logic [7:0]       cur_lvl;
    logic [PRE_W-1:0] cur_pre;
    logic             rise;
    logic             fall;
    logic [3:0]       rate;
    logic [PRE_W:0]   lim_w;
    logic [PRE_W-1:0] limit;
    logic             hit;
    logic [7:0]       sus;
    st_t              nst;
    logic [7:0]       nlvl;
    logic [PRE_W-1:0] npre;

    assign upd = (bus.cnt[7:2] == 6'd0);
    assign v   = bus.cnt[1:0];

    always_comb begin
        cur_st  = st[v];
        cur_lvl = lvl[v];
        cur_pre = pre[v];
        rise    = gate[v] & ~pg[v];
        fall    = ~gate[v] & pg[v];
        sus     = {sustain[{v, 2'b00} +: 4], sustain[{v, 2'b00} +: 4]};
        case (cur_st)
            ST_ATTACK:  rate = attack[{v, 2'b00} +: 4];
            ST_DECAY:   rate = decay[{v, 2'b00} +: 4];
            ST_RELEASE: rate = rel[{v, 2'b00} +: 4];
            default:    rate = 4'd0;
        endcase
        // (rate+1)<<(PRE_W-4) can equal 2^PRE_W; the low bits minus one wrap to all-ones.
        lim_w = ((PRE_W+1)'(rate) + (PRE_W+1)'(1)) << (PRE_W - 4);
        limit = lim_w[PRE_W-1:0] - 1'b1;
        hit   = (cur_pre == limit);

        nst  = cur_st;
        nlvl = cur_lvl;
        npre = cur_pre;
        if (test[v]) begin
            nst  = ST_IDLE;
            nlvl = 8'd0;
            npre = '0;
        end else if (fall && cur_st != ST_IDLE) begin
            nst  = ST_RELEASE;
            npre = '0;
        end else if (rise && (cur_st == ST_IDLE || cur_st == ST_RELEASE)) begin
            nst  = ST_ATTACK;
            npre = '0;
        end else begin
            case (cur_st)
                ST_ATTACK: begin
                    if (hit) begin
                        npre = '0;
                        nlvl = lvl_inc(cur_lvl);
                        if (nlvl == 8'hFF) nst = ST_DECAY;
                    end else begin
                        npre = cur_pre + 1'b1;
                    end
                end
                ST_DECAY: begin
                    if (cur_lvl <= sus) begin
                        nst  = ST_SUSTAIN;
                        npre = '0;
                    end else if (hit) begin
                        npre = '0;
                        nlvl = lvl_dec(cur_lvl);
                    end else begin
                        npre = cur_pre + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (hit) begin
                        npre = '0;
                        nlvl = lvl_dec(cur_lvl);
                        if (nlvl == 8'h00) nst = ST_IDLE;
                    end else begin
                        npre = cur_pre + 1'b1;
                    end
                end
                default: npre = '0;
            endcase
        end
    end

    // Output stage: product uses the level held before this slot's update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                st[k]  <= ST_IDLE;
                lvl[k] <= 8'd0;
                pre[k] <= '0;
            end
            pg          <= 4'd0;
            bus.o       <= 20'd0;
            bus.o_voice <= 2'd0;
            bus.o_vld   <= 1'b0;
        end else begin
            bus.o_vld <= upd;
            if (upd) begin
                st[v]       <= nst;
                lvl[v]      <= nlvl;
                pre[v]      <= npre;
                pg[v]       <= gate[v];
                bus.o       <= 20'(bus.i) * 20'(cur_lvl);
                bus.o_voice <= v;
            end
        end
    end

    assign env0 = lvl[0];
    assign env1 = lvl[1];
    assign env2 = lvl[2];
    assign env3 = lvl[3];
endmodule

// File: tb/tb_psg_envelope_gen.sv
// Bench for psg_envelope_gen: directed ADSR scenarios with a behavioural
// envelope model and an output scoreboard.
`timescale 1ns/1ps
module tb_psg_envelope_gen;
    localparam int PRE_W = 4;
    localparam int S_IDLE = 0, S_ATT = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  gate, test;
    logic [15:0] attack, decay, sustain, rel;
    logic [7:0]  env0, env1, env2, env3;

    psg_envelope_gen_if bus();

    psg_envelope_gen #(.PRE_W(PRE_W)) dut (
        .clk(clk), .rst(rst), .gate(gate), .test(test),
        .attack(attack), .decay(decay), .sustain(sustain), .rel(rel),
        .bus(bus),
        .env0(env0), .env1(env1), .env2(env2), .env3(env3)
    );

    always #5 clk = ~clk;

    int ncheck = 0;
    int npass  = 0;

    int         m_st  [4];
    logic [7:0] m_lvl [4];
    int         m_pre [4];
    logic [3:0] m_pg;

    typedef struct packed {
        logic [19:0] o;
        logic [1:0]  v;
    } exp_t;
    exp_t        q[$];
    logic [19:0] last_o;
    logic [1:0]  last_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncheck++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic int nib(input logic [15:0] f, input int v);
        return int'(f[4*v +: 4]);
    endfunction

    function automatic logic [7:0] env_of(input int v);
        case (v)
            0:       return env0;
            1:       return env1;
            2:       return env2;
            default: return env3;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_st[k]  = S_IDLE;
            m_lvl[k] = 8'd0;
            m_pre[k] = 0;
        end
        m_pg = 4'd0;
    endtask

    task automatic model_update(input int v);
        logic rise, fall;
        int   r, lim, s;
        rise    = gate[v] && !m_pg[v];
        fall    = !gate[v] && m_pg[v];
        m_pg[v] = gate[v];
        if (test[v]) begin
            m_st[v] = S_IDLE; m_lvl[v] = 8'd0; m_pre[v] = 0;
        end else if (fall && m_st[v] != S_IDLE) begin
            m_st[v] = S_REL; m_pre[v] = 0;
        end else if (rise && (m_st[v] == S_IDLE || m_st[v] == S_REL)) begin
            m_st[v] = S_ATT; m_pre[v] = 0;
        end else begin
            case (m_st[v])
                S_ATT:   r = nib(attack, v);
                S_DEC:   r = nib(decay, v);
                S_REL:   r = nib(rel, v);
                default: r = 0;
            endcase
            lim = ((r + 1) << (PRE_W - 4)) - 1;
            s   = nib(sustain, v) * 17;
            if (m_st[v] == S_IDLE || m_st[v] == S_SUS) begin
                m_pre[v] = 0;
            end else if (m_st[v] == S_DEC && int'(m_lvl[v]) <= s) begin
                m_st[v] = S_SUS; m_pre[v] = 0;
            end else if (m_pre[v] != lim) begin
                m_pre[v]++;
            end else begin
                m_pre[v] = 0;
                if (m_st[v] == S_ATT) begin
                    if (m_lvl[v] >= 8'd254) begin m_lvl[v] = 8'd255; m_st[v] = S_DEC; end
                    else m_lvl[v] = m_lvl[v] + 8'd1;
                end else if (m_st[v] == S_DEC) begin
                    m_lvl[v] = m_lvl[v] - 8'd1;
                end else begin
                    if (m_lvl[v] <= 8'd1) begin m_lvl[v] = 8'd0; m_st[v] = S_IDLE; end
                    else m_lvl[v] = m_lvl[v] - 8'd1;
                end
            end
        end
    endtask

    task automatic cycle(input logic [7:0] c, input logic [11:0] iv);
        logic exp_vld;
        exp_t e;
        @(negedge clk);
        bus.cnt = c;
        bus.i   = iv;
        exp_vld = !rst && (c < 8'd4);
        if (rst) begin
            model_reset();
            q.delete();
            last_o = 20'd0;
            last_v = 2'd0;
        end else if (c < 8'd4) begin
            e.o = 20'(iv) * 20'(m_lvl[c[1:0]]);
            e.v = c[1:0];
            q.push_back(e);
            model_update(int'(c[1:0]));
        end
        @(posedge clk);
        #1;
        chk("o_vld", 32'(bus.o_vld), 32'(exp_vld));
        if (q.size() > 0) begin
            e      = q.pop_front();
            last_o = e.o;
            last_v = e.v;
        end
        chk("o", 32'(bus.o), 32'(last_o));
        chk("o_voice", 32'(bus.o_voice), 32'(last_v));
        chk("env0", 32'(env0), 32'(m_lvl[0]));
        chk("env1", 32'(env1), 32'(m_lvl[1]));
        chk("env2", 32'(env2), 32'(m_lvl[2]));
        chk("env3", 32'(env3), 32'(m_lvl[3]));
    endtask

    task automatic upd(input int v, input int n);
        for (int k = 0; k < n; k++) begin
            cycle(8'(v), 12'($urandom));
            if ($urandom_range(0, 3) == 0) cycle(8'($urandom_range(4, 255)), 12'($urandom));
        end
    endtask

    task automatic rounds(input int n);
        for (int k = 0; k < n; k++)
            for (int v = 0; v < 4; v++) cycle(8'(v), 12'($urandom));
    endtask

    task automatic run_to(input int v, input logic [7:0] target, input int budget);
        int k = 0;
        while (m_lvl[v] != target && k < budget) begin
            upd(v, 1);
            k++;
        end
        chk($sformatf("reach_v%0d_lvl%0h", v, target), 32'(env_of(v)), 32'(target));
    endtask

    task automatic run_to_sus(input int v, input int budget);
        int k = 0;
        while (m_st[v] != S_SUS && k < budget) begin
            upd(v, 1);
            k++;
        end
        chk($sformatf("sustain_v%0d", v), 32'(env_of(v)), 32'h88);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; gate = 4'hF; test = 4'h0;
        attack = 16'h0000; decay = 16'h0000; sustain = 16'h8888; rel = 16'h0000;
        bus.cnt = 8'd0; bus.i = 12'hFFF;
        last_o = 20'd0; last_v = 2'd0;
        model_reset();

        // Reset with gates held high and full-scale input.
        for (int v = 0; v < 4; v++) cycle(8'(v), 12'hFFF);
        chk("rst_env3", 32'(env3), 32'd0);
        rst = 1'b0;

        // Held gates look like rises: every voice enters ATTACK, then steps.
        rounds(2);
        chk("first_attack_env0", 32'(env0), 32'd1);
        chk("first_attack_env3", 32'(env3), 32'd1);
        gate = 4'h0;
        rounds(2);
        chk("release_to_idle_env2", 32'(env2), 32'd0);

        // Voice 0: fastest attack to 255, then decay to sustain 0x88.
        gate = 4'b0001;
        upd(0, 1);
        chk("attack_entry_env0", 32'(env0), 32'd0);
        run_to(0, 8'hFF, 300);
        cycle(8'd0, 12'hFFF);
        chk("o_full_scale", 32'(bus.o), 32'h0FEF01);
        chk("o_full_voice", 32'(bus.o_voice), 32'd0);
        cycle(8'd5, 12'h000);
        chk("o_vld_strobe", 32'(bus.o_vld), 32'd0);
        run_to_sus(0, 400);
        upd(0, 5);
        chk("sustain_hold_env0", 32'(env0), 32'h88);

        // Voice 1 attack rate 3: one step per four updates.
        attack = 16'h0030;
        gate   = 4'b0011;
        rounds(9);
        chk("rate3_env1_9", 32'(env1), 32'd2);
        rounds(3);
        chk("rate3_env1_12", 32'(env1), 32'd2);
        rounds(1);
        chk("rate3_env1_13", 32'(env1), 32'd3);
        chk("rate3_env0_untouched", 32'(env0), 32'h88);

        // Gate fall during ATTACK, re-rise during RELEASE, full release.
        attack = 16'h0000;
        run_to(1, 8'd100, 200);
        gate = 4'b0001;
        upd(1, 1);
        chk("fall_no_step_env1", 32'(env1), 32'd100);
        upd(1, 1);
        chk("release_step_env1", 32'(env1), 32'd99);
        run_to(1, 8'd40, 100);
        gate = 4'b0011;
        upd(1, 1);
        chk("rerise_keep_env1", 32'(env1), 32'd40);
        upd(1, 1);
        chk("rerise_step_env1", 32'(env1), 32'd41);
        run_to(1, 8'd100, 100);
        gate = 4'b0001;
        upd(1, 1);
        run_to(1, 8'd0, 120);
        upd(1, 2);
        chk("idle_hold_env1", 32'(env1), 32'd0);

        // Voice 2: test overrides a simultaneous gate fall.
        gate = 4'b0101;
        run_to_sus(2, 600);
        test = 4'b0100;
        gate = 4'b0001;
        cycle(8'd2, 12'hFFF);
        chk("test_o_old_level", 32'(bus.o), 32'h087F78);
        chk("test_env2", 32'(env2), 32'd0);
        cycle(8'd2, 12'hFFF);
        chk("test_o_zero", 32'(bus.o), 32'd0);
        test = 4'b0000;
        upd(2, 2);
        chk("after_test_env2", 32'(env2), 32'd0);
        gate = 4'b0101;
        upd(2, 2);
        chk("retrigger_env2", 32'(env2), 32'd1);

        // Reset mid-envelope with gate 0 held high.
        rst = 1'b1;
        cycle(8'd0, 12'h123);
        cycle(8'd7, 12'h456);
        rst = 1'b0;
        chk("midrst_env0", 32'(env0), 32'd0);
        upd(0, 2);
        chk("midrst_rise_env0", 32'(env0), 32'd1);

        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end
endmodule
